// File: rtl/tt_mask_idx_pkg.sv
`default_nettype none
// ============================================================================
// tt_mask_idx_pkg: shared types for the LSU mask/index channel arbiter
// Rev 1.0
// ============================================================================
package tt_mask_idx_pkg;

    localparam int MASK_IDX_ITEM_W  = 65;
    localparam int MASK_IDX_ENTRY_W = MASK_IDX_ITEM_W + 1;

    typedef struct packed {
        logic        mask;
        logic [63:0] idx;
    } mask_idx_item_t;

    typedef enum logic [0:0] {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } arb_lock_state_t;

endpackage
`default_nettype wire

// File: rtl/tt_mask_idx_fifo.sv
`default_nettype none
// ============================================================================
// tt_mask_idx_fifo: per-requester FIFO; accepts push+pop on a full FIFO
// Rev 1.0
// ============================================================================
module tt_mask_idx_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 66
) (
    input  logic         i_clk,
    input  logic         i_reset_n,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    input  logic         i_pop,
    output logic [W-1:0] o_data,
    output logic         o_empty,
    output logic         o_full,
    output logic         o_overflow
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    always_comb begin
        o_empty    = (count_q == '0);
        o_full     = (count_q == CW'(DEPTH));
        do_pop     = i_pop && !o_empty;
        // A full FIFO still takes a push when the same cycle frees a slot.
        do_push    = i_push && (!o_full || do_pop);
        o_overflow = i_push && !do_push;
        mem_d      = mem_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = i_data;
            wr_ptr_d = (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        count_d = count_q + CW'(do_push) - CW'(do_pop);
    end

    assign o_data = mem_q[rd_ptr_q];

    always_ff @(posedge i_clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/tt_mask_idx_arb.sv
`default_nettype none
// ============================================================================
// tt_mask_idx_arb: shares the LSU mask/index channel, round-robin with packet lock
// Rev 1.0
// ============================================================================
module tt_mask_idx_arb
    import tt_mask_idx_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int REQ_CREDITS = 2,
    parameter int DS_CREDITS  = 2
) (
    input  logic                                 i_clk,
    input  logic                                 i_reset_n,
    input  logic [NUM_REQ-1:0]                   i_req_valid,
    input  logic [NUM_REQ*MASK_IDX_ITEM_W-1:0]   i_req_item,
    input  logic [NUM_REQ-1:0]                   i_req_last,
    output logic [NUM_REQ-1:0]                   o_req_credit,
    input  logic                                 i_ds_credit,
    output logic                                 o_mask_idx_valid,
    output logic [MASK_IDX_ITEM_W-1:0]           o_mask_idx_item,
    output logic                                 o_mask_idx_last_idx,
    output logic                                 o_busy,
    output logic                                 o_err
);

    localparam int RW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int DSW = $clog2(DS_CREDITS + 1) + 1;
    localparam int EW  = MASK_IDX_ENTRY_W;

    logic [EW-1:0]      fifo_rdata [NUM_REQ];
    logic [NUM_REQ-1:0] fifo_empty, fifo_full, fifo_overflow, fifo_pop;
    logic [NUM_REQ-1:0] eligible;

    arb_lock_state_t    lock_q, lock_d;
    logic [RW-1:0]      owner_q, owner_d;
    logic [RW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [DSW-1:0]     ds_credits_q, ds_credits_d, ds_avail;
    logic               valid_q, valid_d;
    mask_idx_item_t     item_q, item_d;
    logic               last_q, last_d;
    logic [NUM_REQ-1:0] credit_q, credit_d;
    logic               err_q, err_d;

    logic [RW-1:0]      winner, cand;
    logic               found, pop;
    logic [EW-1:0]      pop_entry;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_req_fifo
        tt_mask_idx_fifo #(
            .DEPTH (REQ_CREDITS),
            .W     (EW)
        ) u_fifo (
            .i_clk      (i_clk),
            .i_reset_n  (i_reset_n),
            .i_push     (i_req_valid[g]),
            .i_data     ({i_req_last[g], i_req_item[g*MASK_IDX_ITEM_W +: MASK_IDX_ITEM_W]}),
            .i_pop      (fifo_pop[g]),
            .o_data     (fifo_rdata[g]),
            .o_empty    (fifo_empty[g]),
            .o_full     (fifo_full[g]),
            .o_overflow (fifo_overflow[g])
        );
    end

    always_comb begin
        ds_avail = ds_credits_q + DSW'(i_ds_credit);
        for (int i = 0; i < NUM_REQ; i++) begin
            eligible[i] = !fifo_empty[i] && (lock_q == UNLOCKED || owner_q == RW'(i));
        end
        winner = rr_ptr_q;
        cand   = rr_ptr_q;
        found  = 1'b0;
        // Scan from the round-robin pointer; first eligible requester wins.
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = RW'((int'(rr_ptr_q) + k) % NUM_REQ);
            if (!found && eligible[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
        pop       = found && (ds_avail != '0);
        pop_entry = fifo_rdata[winner];
        for (int i = 0; i < NUM_REQ; i++) begin
            fifo_pop[i] = pop && (winner == RW'(i));
        end
    end

    always_comb begin
        lock_d       = lock_q;
        owner_d      = owner_q;
        rr_ptr_d     = rr_ptr_q;
        ds_credits_d = ds_avail - DSW'(pop);
        valid_d      = pop;
        item_d       = item_q;
        last_d       = 1'b0;
        credit_d     = fifo_pop;
        err_d        = err_q | (|(fifo_overflow & fifo_full)) | (ds_credits_d > DSW'(DS_CREDITS));
        if (pop) begin
            item_d = mask_idx_item_t'(pop_entry[EW-2:0]);
            last_d = pop_entry[EW-1];
            if (pop_entry[EW-1]) begin
                lock_d   = UNLOCKED;
                rr_ptr_d = (winner == RW'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
            end else begin
                lock_d  = LOCKED;
                owner_d = winner;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            lock_q       <= UNLOCKED;
            owner_q      <= '0;
            rr_ptr_q     <= '0;
            ds_credits_q <= DSW'(DS_CREDITS);
            valid_q      <= 1'b0;
            item_q       <= '0;
            last_q       <= 1'b0;
            credit_q     <= '0;
            err_q        <= 1'b0;
        end else begin
            lock_q       <= lock_d;
            owner_q      <= owner_d;
            rr_ptr_q     <= rr_ptr_d;
            ds_credits_q <= ds_credits_d;
            valid_q      <= valid_d;
            item_q       <= item_d;
            last_q       <= last_d;
            credit_q     <= credit_d;
            err_q        <= err_d;
        end
    end

    assign o_req_credit        = credit_q;
    assign o_mask_idx_valid    = valid_q;
    assign o_mask_idx_item     = item_q;
    assign o_mask_idx_last_idx = last_q;
    assign o_err               = err_q;
    assign o_busy              = (|(~fifo_empty)) || (lock_q == LOCKED);

endmodule
`default_nettype wire

// File: tb/tb_tt_mask_idx_arb.sv
`default_nettype none
// Bench for tt_mask_idx_arb: directed scenarios plus random traffic against a queue-based model.
module tb_tt_mask_idx_arb;

    localparam int NUM_REQ     = 2;
    localparam int REQ_CREDITS = 2;
    localparam int DS_CREDITS  = 2;
    localparam int IW          = 65;

    logic                    i_clk;
    logic                    i_reset_n;
    logic [NUM_REQ-1:0]      i_req_valid;
    logic [NUM_REQ*IW-1:0]   i_req_item;
    logic [NUM_REQ-1:0]      i_req_last;
    logic [NUM_REQ-1:0]      o_req_credit;
    logic                    i_ds_credit;
    logic                    o_mask_idx_valid;
    logic [IW-1:0]           o_mask_idx_item;
    logic                    o_mask_idx_last_idx;
    logic                    o_busy;
    logic                    o_err;

    tt_mask_idx_arb #(
        .NUM_REQ     (NUM_REQ),
        .REQ_CREDITS (REQ_CREDITS),
        .DS_CREDITS  (DS_CREDITS)
    ) dut (
        .i_clk               (i_clk),
        .i_reset_n           (i_reset_n),
        .i_req_valid         (i_req_valid),
        .i_req_item          (i_req_item),
        .i_req_last          (i_req_last),
        .o_req_credit        (o_req_credit),
        .i_ds_credit         (i_ds_credit),
        .o_mask_idx_valid    (o_mask_idx_valid),
        .o_mask_idx_item     (o_mask_idx_item),
        .o_mask_idx_last_idx (o_mask_idx_last_idx),
        .o_busy              (o_busy),
        .o_err               (o_err)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [IW:0]        mq [NUM_REQ][$];
    int                 m_dsc = DS_CREDITS;
    int                 m_rr = 0;
    int                 m_owner = 0;
    bit                 m_locked = 0;
    logic               ex_valid = 0, ex_last = 0, ex_busy = 0, ex_err = 0;
    logic [IW-1:0]      ex_item = '0;
    logic [NUM_REQ-1:0] ex_credit = '0;
    bit                 chk_en = 0;

    always @(posedge i_clk) begin : model
        int avail, w, j;
        bit popped;
        logic [IW:0] e;
        if (!i_reset_n) begin
            for (int i = 0; i < NUM_REQ; i++) mq[i].delete();
            m_dsc = DS_CREDITS; m_rr = 0; m_owner = 0; m_locked = 0;
            ex_valid = 0; ex_last = 0; ex_busy = 0; ex_err = 0; ex_item = '0; ex_credit = '0;
        end else begin
            avail = m_dsc + int'(i_ds_credit);
            popped = 0; w = 0;
            if (avail > 0) begin
                for (int k = 0; k < NUM_REQ; k++) begin
                    j = (m_rr + k) % NUM_REQ;
                    if (!popped && mq[j].size() > 0 && (!m_locked || m_owner == j)) begin
                        popped = 1; w = j;
                    end
                end
            end
            ex_valid = popped; ex_last = 0; ex_credit = '0;
            if (popped) begin
                e = mq[w].pop_front();
                ex_item = e[IW-1:0];
                ex_last = e[IW];
                ex_credit[w] = 1'b1;
                if (e[IW]) begin m_locked = 0; m_rr = (w + 1) % NUM_REQ; end
                else begin m_locked = 1; m_owner = w; end
            end
            m_dsc = avail - (popped ? 1 : 0);
            if (m_dsc > DS_CREDITS) ex_err = 1;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (i_req_valid[i]) begin
                    if (mq[i].size() < REQ_CREDITS) mq[i].push_back({i_req_last[i], i_req_item[i*IW +: IW]});
                    else ex_err = 1;
                end
            end
            ex_busy = m_locked;
            for (int i = 0; i < NUM_REQ; i++) if (mq[i].size() > 0) ex_busy = 1;
        end
    end

    always @(negedge i_clk) begin : compare
        if (chk_en) begin
            chk("valid",  {127'd0, o_mask_idx_valid},    {127'd0, ex_valid});
            chk("item",   {63'd0, o_mask_idx_item},      {63'd0, ex_item});
            chk("last",   {127'd0, o_mask_idx_last_idx}, {127'd0, ex_last});
            chk("credit", {126'd0, o_req_credit},        {126'd0, ex_credit});
            chk("busy",   {127'd0, o_busy},              {127'd0, ex_busy});
            chk("err",    {127'd0, o_err},               {127'd0, ex_err});
        end
    end

    // ---------------- stimulus helpers ----------------
    int            outstanding = 0;
    int            lsu_mode = 0;          // 0 manual, 1 return asap, 2 random return
    int            cred_cnt [NUM_REQ];
    int            prod_cred [NUM_REQ];
    logic [IW-1:0] cap [$];

    task automatic cyc();
        @(posedge i_clk); #1;
        if (i_ds_credit) outstanding--;
        if (o_mask_idx_valid) begin outstanding++; cap.push_back(o_mask_idx_item); end
        for (int i = 0; i < NUM_REQ; i++) if (o_req_credit[i]) begin cred_cnt[i]++; prod_cred[i]++; end
        i_req_valid = '0; i_req_last = '0; i_ds_credit = 1'b0;
        if (lsu_mode != 0 && outstanding > 0 && (lsu_mode == 1 || $urandom_range(2) != 0)) i_ds_credit = 1'b1;
    endtask

    task automatic cycn(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic push(input int r, input logic last, input logic [IW-1:0] it);
        i_req_valid[r] = 1'b1;
        i_req_last[r]  = last;
        i_req_item[r*IW +: IW] = it;
    endtask

    task automatic do_reset();
        i_reset_n = 1'b0;
        cyc();
        i_reset_n = 1'b1;
        outstanding = 0;
        for (int i = 0; i < NUM_REQ; i++) begin cred_cnt[i] = 0; prod_cred[i] = REQ_CREDITS; end
    endtask

    function automatic logic [IW-1:0] mk(input logic m, input logic [63:0] idx);
        return {m, idx};
    endfunction

    task automatic chk1(input string name, input logic act, input logic exp);
        chk(name, {127'd0, act}, {127'd0, exp});
    endtask

    task automatic chk_cap(input int n, input logic [IW-1:0] e0, input logic [IW-1:0] e1,
                           input logic [IW-1:0] e2, input logic [IW-1:0] e3);
        logic [IW-1:0] ev [4];
        ev[0] = e0; ev[1] = e1; ev[2] = e2; ev[3] = e3;
        chk("cap_count", 128'(cap.size()), 128'(n));
        for (int i = 0; i < n && i < cap.size(); i++) chk("cap_order", {63'd0, cap[i]}, {63'd0, ev[i]});
    endtask

    int pkt_left [NUM_REQ];

    initial begin
        i_reset_n = 1'b0; i_req_valid = '0; i_req_item = '0; i_req_last = '0; i_ds_credit = 1'b0;
        cyc();
        chk_en = 1;
        do_reset();
        chk1("rst_valid", o_mask_idx_valid, 1'b0);
        chk("rst_item", {63'd0, o_mask_idx_item}, 128'd0);
        chk1("rst_last", o_mask_idx_last_idx, 1'b0);
        chk("rst_credit", {126'd0, o_req_credit}, 128'd0);
        chk1("rst_busy", o_busy, 1'b0);
        chk1("rst_err", o_err, 1'b0);

        // 3-item packet from R0 against 2 downstream credits
        lsu_mode = 0;
        push(0, 0, mk(1'b0, 64'hA0)); cyc();
        chk1("t1_no_out_yet", o_mask_idx_valid, 1'b0);
        push(0, 0, mk(1'b1, 64'hA1)); cyc();
        chk1("t1_v0", o_mask_idx_valid, 1'b1);
        chk("t1_i0", {63'd0, o_mask_idx_item}, {63'd0, mk(1'b0, 64'hA0)});
        push(0, 1, mk(1'b0, 64'hA2)); cyc();
        chk("t1_i1", {63'd0, o_mask_idx_item}, {63'd0, mk(1'b1, 64'hA1)});
        cyc();
        chk1("t1_stall", o_mask_idx_valid, 1'b0);
        cyc();
        chk1("t1_stall_busy", o_busy, 1'b1);
        i_ds_credit = 1'b1; cyc();
        chk1("t1_v2", o_mask_idx_valid, 1'b1);
        chk1("t1_last2", o_mask_idx_last_idx, 1'b1);
        chk("t1_i2", {63'd0, o_mask_idx_item}, {63'd0, mk(1'b0, 64'hA2)});
        cyc();
        chk("t1_credits", 128'(cred_cnt[0]), 128'd3);

        // two 2-item packets in contention, then two single-item packets
        do_reset();
        lsu_mode = 1;
        cap.delete();
        push(0, 0, mk(1'b0, 64'h100)); push(1, 0, mk(1'b0, 64'h200)); cyc();
        push(0, 1, mk(1'b1, 64'h101)); push(1, 1, mk(1'b1, 64'h201)); cyc();
        cycn(8);
        chk_cap(4, mk(1'b0, 64'h100), mk(1'b1, 64'h101), mk(1'b0, 64'h200), mk(1'b1, 64'h201));
        cap.delete();
        push(0, 1, mk(1'b0, 64'h300)); push(1, 1, mk(1'b0, 64'h400)); cyc();
        cycn(6);
        chk_cap(2, mk(1'b0, 64'h300), mk(1'b0, 64'h400), '0, '0);

        // same-cycle downstream credit return with zero credits held
        lsu_mode = 0;
        push(0, 1, mk(1'b0, 64'h11)); cyc();
        push(0, 1, mk(1'b0, 64'h12)); cyc();
        cycn(2);
        push(1, 1, mk(1'b1, 64'h13)); cyc();
        cycn(2);
        chk1("t4_held", o_mask_idx_valid, 1'b0);
        i_ds_credit = 1'b1; cyc();
        chk1("t4_v", o_mask_idx_valid, 1'b1);
        chk("t4_item", {63'd0, o_mask_idx_item}, {63'd0, mk(1'b1, 64'h13)});
        push(1, 1, mk(1'b0, 64'h14)); cyc();
        cycn(2);
        chk1("t4_still_zero", o_mask_idx_valid, 1'b0);
        lsu_mode = 1; cycn(10);

        // reset while locked with one item buffered
        lsu_mode = 0;
        push(0, 0, mk(1'b0, 64'h50)); cyc();
        push(0, 0, mk(1'b0, 64'h51)); cyc();
        push(0, 1, mk(1'b0, 64'h52)); cyc();
        cycn(2);
        chk1("t5_locked_busy", o_busy, 1'b1);
        do_reset();
        chk1("t5_rst_valid", o_mask_idx_valid, 1'b0);
        chk1("t5_rst_busy", o_busy, 1'b0);
        chk("t5_rst_credit", {126'd0, o_req_credit}, 128'd0);
        push(1, 1, mk(1'b1, 64'h60)); cyc();
        cyc();
        chk1("t5_fwd_v", o_mask_idx_valid, 1'b1);
        chk("t5_fwd_item", {63'd0, o_mask_idx_item}, {63'd0, mk(1'b1, 64'h60)});
        chk("t5_fwd_credit", {126'd0, o_req_credit}, 128'd2);

        // FIFO overflow from a producer ignoring credits
        do_reset();
        push(0, 1, mk(1'b0, 64'h70)); cyc();
        push(0, 1, mk(1'b0, 64'h71)); cyc();
        cycn(2);
        push(0, 0, mk(1'b0, 64'h72)); cyc();
        chk1("t6_no_err_yet", o_err, 1'b0);
        push(0, 0, mk(1'b0, 64'h73)); cyc();
        push(0, 1, mk(1'b0, 64'h74)); cyc();
        chk1("t6_err", o_err, 1'b1);
        cycn(4);
        chk1("t6_err_sticky", o_err, 1'b1);
        do_reset();
        chk1("t6_err_cleared", o_err, 1'b0);

        // random traffic honouring both credit loops
        lsu_mode = 2;
        for (int i = 0; i < NUM_REQ; i++) pkt_left[i] = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (prod_cred[i] > 0 && $urandom_range(1) == 1) begin
                    if (pkt_left[i] == 0) pkt_left[i] = $urandom_range(4, 1);
                    push(i, pkt_left[i] == 1, mk(1'($urandom), {$urandom, $urandom}));
                    pkt_left[i]--;
                    prod_cred[i]--;
                end
            end
            cyc();
        end
        // finish any open packets, then drain
        for (int c = 0; c < 40; c++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (pkt_left[i] > 0 && prod_cred[i] > 0) begin
                    push(i, pkt_left[i] == 1, mk(1'($urandom), {$urandom, $urandom}));
                    pkt_left[i]--;
                    prod_cred[i]--;
                end
            end
            cyc();
        end
        lsu_mode = 1;
        cycn(20);
        chk1("drain_busy", o_busy, 1'b0);
        chk1("drain_err", o_err, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tt_mask_idx_arb.md
Name: tt_mask_idx_arb

Overview:
- Shares the single LSU mask/index channel between NUM_REQ mask/index producers, one per vector memop pipe; each producer runs its own credit-based mask/index FSM.
- Buffers each producer's items in a private FIFO, then arbitrates round-robin with packet lock, so a memop's items are never interleaved with another's.
- Runs two credit loops: one upstream per requester (this block returns credits) and one downstream to the LSU (this block consumes credits).

Parameters:
- NUM_REQ, 2, number of mask/index producers.
- REQ_CREDITS, 2, FIFO depth per requester; equals the MASK_CREDITS each producer resets to.
- DS_CREDITS, 2, credits the LSU grants this block at reset.

Ports:
- i_clk  in  1  clock
- i_reset_n  in  1  synchronous active-low reset
- i_req_valid  in  NUM_REQ  item push, one bit per requester
- i_req_item  in  NUM_REQ*65  packed items; bit 64 = mask, [63:0] = index or mask word
- i_req_last  in  NUM_REQ  item is final of its memop
- o_req_credit  out  NUM_REQ  one-cycle credit return per requester
- i_ds_credit  in  1  LSU returns one credit
- o_mask_idx_valid  out  1  item to LSU
- o_mask_idx_item  out  65  forwarded item
- o_mask_idx_last_idx  out  1  forwarded last flag
- o_busy  out  1  any FIFO non-empty, or lock held
- o_err  out  1  sticky: FIFO overflow or downstream credit overflow

Behaviour:
- Reset: i_reset_n is synchronous, active-low; clock is i_clk. On reset:
  - FIFOs empty; lock cleared; RR pointer = 0; ds_credits = DS_CREDITS.
  - All outputs 0: o_req_credit, o_mask_idx_valid, o_mask_idx_item, o_mask_idx_last_idx, o_busy, o_err.
  - Reset mid-packet discards all buffered items; no credits are returned for them (producers are reset together with this block).
- Push: i_req_valid[i] at cycle t writes {last,item} into FIFO i, visible to arbitration at t+1. A push to a full FIFO is dropped and sets o_err.
- Downstream credit:
  - ds_avail = ds_credits + i_ds_credit (same-cycle return is usable).
  - ds_credits_next = ds_credits + i_ds_credit - pop. Width is $clog2(DS_CREDITS+1)+1.
  - Exceeding DS_CREDITS sets o_err.
- Eligibility: eligible[i] = FIFO i non-empty && (!locked || owner == i).
- Pop: when ds_avail > 0 and any bit of eligible is set, exactly one FIFO pops. The winner is chosen round-robin starting at rr_ptr.
- Lock FSM (states UNLOCKED, LOCKED):
  - UNLOCKED -> LOCKED: pop with last = 0; owner = winner.
  - LOCKED -> UNLOCKED: owner pops with last = 1.
  - A pop with last = 1 while UNLOCKED (single-item packet) stays UNLOCKED.
  - rr_ptr advances to winner+1 (mod NUM_REQ) only on a pop with last = 1.
- Output timing:
  - Outputs are registered: a pop at cycle t drives o_mask_idx_valid = 1, item and last at t+1, and o_req_credit[winner] = 1 at t+1.
  - o_mask_idx_item holds its value when valid = 0.
  - Minimum latency from push to output is 2 cycles.
- Simultaneous events:
  - Push and pop on the same FIFO in the same cycle is legal, including when the FIFO is full.
  - An i_ds_credit arriving with ds_credits = 0 permits a pop in that same cycle.
- o_busy is combinational: OR of FIFO non-empty, or LOCKED.

Decomposition:
- Package tt_mask_idx_pkg holds:
  - MASK_IDX_ITEM_W = 65.
  - typedef mask_idx_item_t: struct {mask, idx[63:0]}.
  - enum arb_lock_state_t {UNLOCKED, LOCKED}.
- Sub-module tt_mask_idx_fifo holds the per-requester FIFO:
  - Parameters: DEPTH = REQ_CREDITS, W = 66.
  - Ports: push, pop, data, empty, full, overflow.
  - Instantiated NUM_REQ times via generate.

Test Plan:
- Req0 pushes 3 items (last on the third), ds credits 2, no LSU return -> 2 items out at t+2 and t+3, then a stall. On i_ds_credit the third item appears the next cycle with last = 1. o_req_credit[0] pulses 3 times.
- Req0 and Req1 push 2-item packets in the same cycle, rr_ptr = 0 -> output order R0a, R0b, R1a, R1b. No interleave despite R1 waiting.
- Next contention (both push 1-item packets) after R1 finished -> R0 wins, since rr_ptr = 0 after the R1 last pop.
- ds_credits = 0, one item queued, i_ds_credit pulses -> pop that cycle, o_mask_idx_valid at the next cycle, ds_credits remains 0.
- Reset asserted while LOCKED with 1 item buffered -> next cycle all outputs 0, o_busy = 0. A fresh single-item push from Req1 is forwarded normally.
- Req0 pushes 3 items with no credit return (protocol violation) -> third push dropped, o_err = 1 and sticky until reset.
